// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions: operation codes, MIPS opcode/funct constants and the
// issue-buffer entry layout used by the decoder, the issue stage and the ALU.
package mips_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ILLEGAL  = 4'b0000,
    ALU_SUB      = 4'b0001,
    ALU_OR       = 4'b0010,
    ALU_ADD      = 4'b0011,
    ALU_LUI      = 4'b0100,
    ALU_SLL      = 4'b0101,
    ALU_SRL      = 4'b0110,
    ALU_AND      = 4'b0111,
    ALU_NOR      = 4'b1000,
    ALU_NOTANDPC = 4'b1010
  } alu_op_e;

  // Source of the b operand
  typedef enum logic [1:0] {
    B_SEL_RT,
    B_SEL_SEXT,
    B_SEL_ZEXT
  } b_sel_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        illegal;
  } issue_entry_t;

  function automatic logic [31:0] select_b(input b_sel_e sel, input logic [15:0] imm,
                                           input logic [31:0] rt);
    logic [31:0] b;
    unique case (sel)
      B_SEL_SEXT: b = {{16{imm[15]}}, imm};
      B_SEL_ZEXT: b = {16'h0000, imm};
      default:    b = rt;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction decoder: maps opcode/funct to an ALU operation,
// the b-operand source and an illegal flag.
module alu_op_decoder
  import mips_alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_e     op,
  output b_sel_e      b_sel,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    op      = ALU_ILLEGAL;
    b_sel   = B_SEL_RT;
    illegal = 1'b0;
    if (opcode == OPC_RTYPE) begin
      unique case (funct)
        FN_ADD, FN_ADDU: op = ALU_ADD;
        FN_SUB, FN_SUBU: op = ALU_SUB;
        FN_AND:          op = ALU_AND;
        FN_OR:           op = ALU_OR;
        FN_NOR:          op = ALU_NOR;
        FN_SLL:          op = ALU_SLL;
        FN_SRL:          op = ALU_SRL;
        FN_JR:           op = ALU_NOTANDPC;
        default:         illegal = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
          op    = ALU_ADD;
          b_sel = B_SEL_SEXT;
        end
        OPC_BEQ, OPC_BNE: op = ALU_SUB;
        OPC_ANDI: begin
          op    = ALU_AND;
          b_sel = B_SEL_ZEXT;
        end
        OPC_ORI: begin
          op    = ALU_OR;
          b_sel = B_SEL_ZEXT;
        end
        OPC_LUI: begin
          op    = ALU_LUI;
          b_sel = B_SEL_ZEXT;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue buffer between register read and the ALU: decodes on accept,
// holds entries in order and presents the head with a valid/ready handshake.
module alu_issue_stage
  import mips_alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [3:0]  alu_operation_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [4:0]  shamt_o,
  output logic        illegal_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  issue_entry_t entries_q [DEPTH];
  logic [1:0]   count_q;
  logic         wr_ptr_q;
  logic         rd_ptr_q;

  alu_op_e      dec_op;
  b_sel_e       dec_b_sel;
  logic         dec_illegal;
  issue_entry_t new_entry;
  issue_entry_t head;
  logic         accept;
  logic         issue;

  alu_op_decoder u_decoder (
    .instr   (instr_i),
    .op      (dec_op),
    .b_sel   (dec_b_sel),
    .illegal (dec_illegal)
  );

  // Illegal entries carry zero operands but keep shamt for in-order traceability
  always_comb begin
    new_entry.op      = dec_op;
    new_entry.shamt   = instr_i[10:6];
    new_entry.illegal = dec_illegal;
    new_entry.a       = dec_illegal ? '0 : rs_data_i;
    new_entry.b       = dec_illegal ? '0 : select_b(dec_b_sel, instr_i[15:0], rt_data_i);
  end

  assign in_ready_o  = (count_q < FULL);
  assign out_valid_o = (count_q != '0);
  assign accept      = in_valid_i && in_ready_o && !flush_i;
  assign issue       = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept) begin
        entries_q[wr_ptr_q] <= new_entry;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (issue) rd_ptr_q <= ~rd_ptr_q;
      unique case ({accept, issue})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head            = out_valid_o ? entries_q[rd_ptr_q] : '0;
  assign alu_operation_o = head.op;
  assign a_o             = head.a;
  assign b_o             = head.b;
  assign shamt_o         = head.shamt;
  assign illegal_o       = head.illegal;

endmodule
